ifu_fetch: RTL
==============

Name: ifu_fetch

Overview:
- Instruction fetch stage that sits between the instruction memory bus and the execute unit. It owns the sequential fetch PC.
- Per response it issues one halfword-aligned 32-bit fetch, decodes the instruction length (16/32 bit), and buffers up to DEPTH instructions with their PCs.
- It presents buffered instructions to the EXU with a valid/ready handshake.
- Flushes (branch, jump, trap) redirect the fetch PC, drop buffered entries and discard any stale in-flight response.

Parameters:
PC_SIZE, 32, width of all PC/address signals
RESET_PC, 32'h0000_0000, fetch PC after reset
DEPTH, 2, instruction buffer entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_flush  in  1  redirect request (branch/jump/irq/excp)
i_flush_pc  in  PC_SIZE  redirect target
ifu_req_valid  out  1  fetch request valid
ifu_req_ready  in  1  memory accepts request
ifu_req_addr  out  PC_SIZE  fetch address (halfword aligned)
ifu_rsp_valid  in  1  fetch response valid (in order, >=1 cycle after accept)
ifu_rsp_rdata  in  32  fetched bits, bits[15:0] at ifu_req_addr
ifu_rsp_err  in  1  bus error on this fetch
ifu_rsp_ready  out  1  always 1
o_ir_valid  out  1  instruction available to EXU
i_exu_ready  in  1  EXU consumes instruction
o_ir  out  32  instruction (upper 16 bits zeroed for 16-bit)
o_ir_pc  out  PC_SIZE  PC of o_ir
o_ir_rv32  out  1  1 = 32-bit instruction (rdata[1:0]==2'b11)
o_ir_buserr  out  1  fetch bus error flag for this entry

Behaviour:
- Reset (async, rst_n low): state=REQ, fetch_pc=RESET_PC, buffer empty, drop=0. Outputs: o_ir_valid=0, o_ir/o_ir_pc/o_ir_rv32/o_ir_buserr=0, ifu_req_valid=0 during reset. Reset mid-transaction abandons it; no response is expected afterwards.
- FSM states:
  - REQ: ifu_req_valid=1, addr=fetch_pc. On ifu_req_ready go to WAIT.
  - WAIT: on rsp_valid go to REQ if buffer has a free slot after this cycle's push/pop, else HOLD.
  - HOLD: ifu_req_valid=0. Go to REQ once count<DEPTH.
- Exactly one request is outstanding at a time.
- Response accepted with drop=0:
  - Push {rdata masked by length, fetch_pc, rv32, err}.
  - fetch_pc += 4 if rv32, else += 2, modulo 2^PC_SIZE (wrap allowed).
  - On err: push an entry with buserr=1 and ir=0, fetch_pc += 4, then stop fetching (HOLD) until a flush.
- Buffer: FIFO, count 0..DEPTH, with wrap-around read/write pointers.
  - Pop on o_ir_valid & i_exu_ready.
  - Push and pop in the same cycle is allowed when full (count unchanged).
  - o_ir_valid = (count != 0). Head outputs are stable while o_ir_valid & ~i_exu_ready.
- Flush (highest priority, takes effect at the clock edge):
  - Buffer cleared; any same-cycle pop is ignored. fetch_pc <= i_flush_pc; err-stop cleared.
  - REQ with no handshake: go to REQ; the address changes next cycle (request abandoned).
  - REQ with handshake in the same cycle: go to WAIT with drop=1.
  - WAIT without rsp: drop=1, stay in WAIT.
  - WAIT with rsp in the same cycle: response discarded, go to REQ, drop=0.
  - HOLD: go to REQ.
- A response arriving with drop=1 is discarded, drop clears, FSM goes to REQ, and fetch_pc is unchanged.
- i_flush_pc[0] is ignored (forced 0).
- Latency: response edge to o_ir_valid = 1 cycle. Request address to o_ir_valid >= 2 cycles.

Optional Feature:
IFU_BYPASS_EN:
- Defined: when the buffer is empty, drop=0, no flush and rsp_valid=1, the response is driven combinationally onto o_ir* with o_ir_valid=1 in the same cycle.
  - If i_exu_ready=1 it is consumed and not written to the buffer.
  - Otherwise it is written to the buffer as normal.
- Undefined: every response goes through the buffer, giving 1-cycle latency.

Test Plan:
- Reset release, memory with 1-cycle latency returning 32'h0000_0013 at 0x0: ifu_req_addr=0x0, next 0x4; o_ir_pc=0x0, o_ir_rv32=1, o_ir=0x13.
- Compressed then 32-bit: rdata 32'hxxxx_4501 at 0x0, then 32'h0010_0093 at 0x2: o_ir=0x0000_4501 rv32=0 pc=0x0, next pc=0x2 rv32=1, next request 0x6.
- EXU stalled (i_exu_ready=0) with DEPTH=2: after 2 entries, ifu_req_valid=0 (HOLD). Raise ready for 1 cycle: exactly one pop, then one new request.
- Flush while WAIT (flush_pc=0x100) and response returns 3 cycles later: the response is discarded and o_ir_valid stays 0. Next request is addr=0x100, and the first presented o_ir_pc=0x100.
- Flush in the same cycle as a response and a pop with count=2: buffer empty next cycle, response dropped, ifu_req_addr=flush_pc.
- ifu_rsp_err=1 at 0x40: entry with o_ir_buserr=1, o_ir=0, o_ir_pc=0x40, and no further requests until a flush to 0x80 restarts fetch at 0x80.

Source files
------------

// File: rtl/ifu_fetch.sv
//==============================================================================
// Module      : ifu_fetch
// Description : Instruction fetch stage. Owns the sequential fetch PC, issues
//               one outstanding halfword-aligned fetch at a time, decodes
//               16/32-bit length and buffers instructions for the EXU.
//               Optional macro IFU_BYPASS_EN forwards a response straight to
//               the EXU when the buffer is empty.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ifu_fetch #(
   parameter int unsigned          PC_SIZE  = 32,
   parameter logic [PC_SIZE-1:0]   RESET_PC = {PC_SIZE{1'b0}},
   parameter int unsigned          DEPTH    = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_flush,
   input  logic [PC_SIZE-1:0]  i_flush_pc,
   output logic                ifu_req_valid,
   input  logic                ifu_req_ready,
   output logic [PC_SIZE-1:0]  ifu_req_addr,
   input  logic                ifu_rsp_valid,
   input  logic [31:0]         ifu_rsp_rdata,
   input  logic                ifu_rsp_err,
   output logic                ifu_rsp_ready,
   output logic                o_ir_valid,
   input  logic                i_exu_ready,
   output logic [31:0]         o_ir,
   output logic [PC_SIZE-1:0]  o_ir_pc,
   output logic                o_ir_rv32,
   output logic                o_ir_buserr
);

   localparam int unsigned c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned c_cnt_w = $clog2(DEPTH + 1);

   localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(DEPTH);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
   localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
   localparam logic [PC_SIZE-1:0] c_pc_one   = PC_SIZE'(1);
   localparam logic [PC_SIZE-1:0] c_pc_two   = PC_SIZE'(2);
   localparam logic [PC_SIZE-1:0] c_pc_four  = PC_SIZE'(4);

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t              r_state;
   logic                r_req_valid;
   logic [PC_SIZE-1:0]  r_fetch_pc;
   logic                r_drop;
   logic                r_err_stop;

   logic [31:0]         r_buf_ir   [DEPTH];
   logic [PC_SIZE-1:0]  r_buf_pc   [DEPTH];
   logic                r_buf_rv32 [DEPTH];
   logic                r_buf_err  [DEPTH];
   logic [c_ptr_w-1:0]  r_wptr;
   logic [c_ptr_w-1:0]  r_rptr;
   logic [c_cnt_w-1:0]  r_count;

   logic                w_req_fire;
   logic                w_rsp_fire;
   logic                w_rsp_take;
   logic                w_is_rv32;
   logic                w_new_rv32;
   logic [31:0]         w_new_ir;
   logic                w_buf_empty;
   logic                w_bypass;
   logic                w_buf_pop;
   logic                w_push;
   logic [c_cnt_w-1:0]  w_count_next;
   logic [PC_SIZE-1:0]  w_pc_step;
   logic [PC_SIZE-1:0]  w_flush_pc;

   assign w_req_fire  = r_req_valid & ifu_req_ready;
   assign w_rsp_fire  = ifu_rsp_valid & (r_state == ST_WAIT);
   assign w_rsp_take  = w_rsp_fire & ~r_drop & ~i_flush;
   assign w_is_rv32   = (ifu_rsp_rdata[1:0] == 2'b11);
   // A faulting fetch carries no instruction; it still steps the PC by a word.
   assign w_new_rv32  = ifu_rsp_err | w_is_rv32;
   assign w_new_ir    = ifu_rsp_err ? 32'h0 :
                        (w_is_rv32 ? ifu_rsp_rdata : {16'h0, ifu_rsp_rdata[15:0]});
   assign w_pc_step   = w_new_rv32 ? c_pc_four : c_pc_two;
   assign w_flush_pc  = i_flush_pc & ~c_pc_one;
   assign w_buf_empty = (r_count == '0);

`ifdef IFU_BYPASS_EN
   assign w_bypass    = w_rsp_take & w_buf_empty;
`else
   assign w_bypass    = 1'b0;
`endif

   assign w_buf_pop   = ~w_buf_empty & i_exu_ready & ~i_flush;
   assign w_push      = w_rsp_take & ~(w_bypass & i_exu_ready);

   always_comb begin
      w_count_next = r_count;
      case ({w_push, w_buf_pop})
         2'b10:   w_count_next = r_count + c_cnt_one;
         2'b01:   w_count_next = r_count - c_cnt_one;
         default: w_count_next = r_count;
      endcase
   end

   // Fetch FSM; ifu_req_valid is registered alongside every state update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_REQ;
         r_req_valid <= 1'b0;
         r_fetch_pc  <= RESET_PC;
         r_drop      <= 1'b0;
         r_err_stop  <= 1'b0;
      end else if (i_flush) begin
         r_fetch_pc <= w_flush_pc;
         r_err_stop <= 1'b0;
         if (((r_state == ST_REQ) && w_req_fire) ||
             ((r_state == ST_WAIT) && !ifu_rsp_valid)) begin
            r_state     <= ST_WAIT;
            r_req_valid <= 1'b0;
            r_drop      <= 1'b1;
         end else begin
            r_state     <= ST_REQ;
            r_req_valid <= 1'b1;
            r_drop      <= 1'b0;
         end
      end else begin
         case (r_state)
            ST_REQ: begin
               if (w_req_fire) begin
                  r_state     <= ST_WAIT;
                  r_req_valid <= 1'b0;
               end else begin
                  r_req_valid <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (ifu_rsp_valid) begin
                  r_drop <= 1'b0;
                  if (r_drop) begin
                     r_state     <= ST_REQ;
                     r_req_valid <= 1'b1;
                  end else begin
                     r_fetch_pc <= r_fetch_pc + w_pc_step;
                     if (ifu_rsp_err) begin
                        r_err_stop  <= 1'b1;
                        r_state     <= ST_HOLD;
                        r_req_valid <= 1'b0;
                     end else if (w_count_next < c_depth) begin
                        r_state     <= ST_REQ;
                        r_req_valid <= 1'b1;
                     end else begin
                        r_state     <= ST_HOLD;
                        r_req_valid <= 1'b0;
                     end
                  end
               end
            end
            ST_HOLD: begin
               if (!r_err_stop && (r_count < c_depth)) begin
                  r_state     <= ST_REQ;
                  r_req_valid <= 1'b1;
               end
            end
            default: begin
               r_state     <= ST_REQ;
               r_req_valid <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_buf_ir[i]   <= 32'h0;
            r_buf_pc[i]   <= '0;
            r_buf_rv32[i] <= 1'b0;
            r_buf_err[i]  <= 1'b0;
         end
      end else if (i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_buf_ir[r_wptr]   <= w_new_ir;
            r_buf_pc[r_wptr]   <= r_fetch_pc;
            r_buf_rv32[r_wptr] <= w_new_rv32;
            r_buf_err[r_wptr]  <= ifu_rsp_err;
            r_wptr             <= r_wptr + c_ptr_one;
         end
         if (w_buf_pop) begin
            r_rptr <= r_rptr + c_ptr_one;
         end
         r_count <= w_count_next;
      end
   end

   assign ifu_req_valid = r_req_valid;
   assign ifu_req_addr  = r_fetch_pc;
   assign ifu_rsp_ready = 1'b1;

   assign o_ir_valid    = ~w_buf_empty | w_bypass;
   assign o_ir          = w_bypass ? w_new_ir    : r_buf_ir[r_rptr];
   assign o_ir_pc       = w_bypass ? r_fetch_pc  : r_buf_pc[r_rptr];
   assign o_ir_rv32     = w_bypass ? w_new_rv32  : r_buf_rv32[r_rptr];
   assign o_ir_buserr   = w_bypass ? ifu_rsp_err : r_buf_err[r_rptr];

endmodule

`default_nettype wire
